// File: rtl/regfile_writeback.sv
// Register-file write front end: ALU results take priority over a DEPTH-entry load queue; one registered write per cycle.
// Latency: one cycle from selection to rf_*. Backpressure: ld_ready falls only when the queue is full; the ALU path is never stalled.
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  input  logic [4:0]      alu_wa,
  input  logic [XLEN-1:0] alu_wd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_wa,
  input  logic [XLEN-1:0] ld_wd,
  output logic            rf_en,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  input  logic [4:0]      fwd_addr,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic [31:0]     pend_mask
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic            live;
    logic [4:0]      wa;
    logic [XLEN-1:0] wd;
  } ent_t;

  ent_t            q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            squash;
  logic [DEPTH-1:0] occ;

  assign ld_ready = (count < CW'(DEPTH));
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (count != '0);
  assign squash   = alu_valid && (alu_wa != 5'd0);

  // Slots between head and head+count-1 (with wrap) hold real entries.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) occ[PW'(head + PW'(k))] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      // Queued loads are older than this ALU result, so their write to the same register is dead.
      for (int i = 0; i < DEPTH; i++) begin
        if (squash && occ[i] && (q[i].wa == alu_wa)) q[i].live <= 1'b0;
      end
      if (push) begin
        q[tail].live <= (ld_wa != 5'd0);
        q[tail].wa   <= ld_wa;
        q[tail].wd   <= ld_wd;
        tail         <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_en <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (alu_valid) begin
      rf_en <= (alu_wa != 5'd0);
      rf_wa <= alu_wa;
      rf_wd <= alu_wd;
    end else if (pop) begin
      rf_en <= q[head].live;
      rf_wa <= q[head].wa;
      rf_wd <= q[head].wd;
    end else begin
      rf_en <= 1'b0;
    end
  end

  // Walk oldest to newest so the last match left standing is the newest.
  always_comb begin
    logic            qhit;
    logic [XLEN-1:0] qdata;
    logic [PW-1:0]   idx;
    qhit     = 1'b0;
    qdata    = '0;
    idx      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = PW'(head + PW'(k));
      if ((CW'(k) < count) && q[idx].live && (q[idx].wa == fwd_addr)) begin
        qhit  = 1'b1;
        qdata = q[idx].wd;
      end
    end
    if (fwd_addr != 5'd0) begin
      if (qhit) begin
        fwd_hit  = 1'b1;
        fwd_data = qdata;
      end else if (rf_en && (rf_wa == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = rf_wd;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && q[i].live) pend_mask[q[i].wa] = 1'b1;
    end
    if (rf_en) pend_mask[rf_wa] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and random stimulus for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk;
  logic            rst_n;
  logic            alu_valid;
  logic [4:0]      alu_wa;
  logic [XLEN-1:0] alu_wd;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_wa;
  logic [XLEN-1:0] ld_wd;
  logic            rf_en;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [4:0]      fwd_addr;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;
  logic [31:0]     pend_mask;

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .rf_en(rf_en), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        live;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ment_t;

  ment_t       mq[$];
  logic        mo_en;
  logic [4:0]  mo_wa;
  logic [31:0] mo_wd;
  logic [31:0] mfile [32];
  logic [31:0] dutf  [32];
  logic        acc;
  int          checks;
  int          errors;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mfile[i] = '0;
      dutf[i]  = '0;
    end
  end

  always @(posedge clk) if (rf_en) dutf[rf_wa] <= rf_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model, advance the model, check rf_* after the edge.
  task automatic cyc();
    logic        mready;
    logic [31:0] epend;
    logic        ehit;
    logic [31:0] edata;
    ment_t       e;
    #2;
    mready = (mq.size() < DEPTH);
    epend  = '0;
    foreach (mq[i]) if (mq[i].live) epend[mq[i].wa] = 1'b1;
    if (mo_en) epend[mo_wa] = 1'b1;
    ehit  = 1'b0;
    edata = '0;
    if (fwd_addr != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!ehit && mq[i].live && mq[i].wa == fwd_addr) begin
          ehit  = 1'b1;
          edata = mq[i].wd;
        end
      end
      if (!ehit && mo_en && mo_wa == fwd_addr) begin
        ehit  = 1'b1;
        edata = mo_wd;
      end
    end
    chk("ld_ready", 32'(ld_ready), 32'(mready));
    chk("pend_mask", pend_mask, epend);
    chk("fwd_hit", 32'(fwd_hit), 32'(ehit));
    chk("fwd_data", fwd_data, edata);

    acc = ld_valid && mready;
    if (mo_en) mfile[mo_wa] = mo_wd;
    if (alu_valid) begin
      if (alu_wa != 5'd0) foreach (mq[i]) if (mq[i].wa == alu_wa) mq[i].live = 1'b0;
      mo_en = (alu_wa != 5'd0);
      mo_wa = alu_wa;
      mo_wd = alu_wd;
    end else if (mq.size() > 0) begin
      e     = mq.pop_front();
      mo_en = e.live;
      mo_wa = e.wa;
      mo_wd = e.wd;
    end else begin
      mo_en = 1'b0;
    end
    if (acc) begin
      e.live = (ld_wa != 5'd0);
      e.wa   = ld_wa;
      e.wd   = ld_wd;
      mq.push_back(e);
    end

    @(posedge clk);
    #1;
    chk("rf_en", 32'(rf_en), 32'(mo_en));
    chk("rf_wa", 32'(rf_wa), 32'(mo_wa));
    chk("rf_wd", rf_wd, mo_wd);
  endtask

  initial begin
    int k;
    checks    = 0;
    errors    = 0;
    acc       = 1'b0;
    mo_en     = 1'b0;
    mo_wa     = '0;
    mo_wd     = '0;
    rst_n     = 1'b0;
    alu_valid = 1'b0;
    alu_wa    = '0;
    alu_wd    = '0;
    ld_valid  = 1'b0;
    ld_wa     = '0;
    ld_wd     = '0;
    fwd_addr  = '0;

    // Reset state
    #2;
    chk("rst_rf_en", 32'(rf_en), 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_rf_wd", rf_wd, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_pend", pend_mask, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU only
    alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEADBEEF; fwd_addr = 5'd5;
    cyc();
    chk("alu_en", 32'(rf_en), 32'd1);
    chk("alu_wd", rf_wd, 32'hDEADBEEF);
    alu_valid = 1'b0;
    cyc();
    chk("alu_en_after", 32'(rf_en), 32'd0);
    cyc();

    // Queue fill under continuous ALU traffic
    alu_valid = 1'b1; alu_wa = 5'd9; alu_wd = 32'h99; ld_valid = 1'b1; fwd_addr = 5'd2;
    k = 1;
    repeat (6) begin
      ld_wa = 5'(k); ld_wd = 32'h100 + 32'(k);
      cyc();
      if (acc) k++;
    end
    chk("fill_held", 32'(ld_ready), 32'd0);
    alu_valid = 1'b0;
    cyc();
    chk("fill_first_pop", 32'(rf_wa), 32'd1);
    if (acc) k++;
    repeat (7) begin
      ld_valid = (k <= 5); ld_wa = 5'(k); ld_wd = 32'h100 + 32'(k);
      cyc();
      if (acc) k++;
    end
    chk("fill_x5", dutf[5], 32'h105);
    ld_valid = 1'b0;

    // Squash of an older queued load by a newer ALU write
    alu_valid = 1'b1; alu_wa = 5'd0; ld_valid = 1'b1; ld_wa = 5'd7; ld_wd = 32'h11; fwd_addr = 5'd7;
    cyc();
    ld_valid = 1'b0; alu_wa = 5'd7; alu_wd = 32'h22;
    cyc();
    alu_valid = 1'b0;
    #1;
    chk("squash_fwd_hit", 32'(fwd_hit), 32'd1);
    chk("squash_fwd_data", fwd_data, 32'h22);
    cyc();
    chk("squash_dead_pop", 32'(rf_en), 32'd0);
    repeat (2) cyc();
    chk("squash_x7", dutf[7], 32'h22);

    // Forwarding priority: younger queue entry beats the output stage
    alu_valid = 1'b1; alu_wa = 5'd3; alu_wd = 32'hA; ld_valid = 1'b1; ld_wa = 5'd3; ld_wd = 32'hB;
    cyc();
    ld_valid = 1'b0; alu_wa = 5'd0; fwd_addr = 5'd3;
    #1;
    chk("prio_hit", 32'(fwd_hit), 32'd1);
    chk("prio_data", fwd_data, 32'hB);
    fwd_addr = 5'd0;
    #1;
    chk("prio_x0_hit", 32'(fwd_hit), 32'd0);
    fwd_addr = 5'd3;
    cyc();
    alu_valid = 1'b0;
    repeat (3) cyc();

    // x0 writes from both sources
    alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'h55; ld_valid = 1'b1; ld_wa = 5'd0; ld_wd = 32'h66; fwd_addr = 5'd0;
    cyc();
    chk("x0_alu_en", 32'(rf_en), 32'd0);
    alu_valid = 1'b0; ld_valid = 1'b0;
    cyc();
    chk("x0_ld_en", 32'(rf_en), 32'd0);
    chk("x0_pend0", 32'(pend_mask[0]), 32'd0);
    cyc();

    // Mid-operation reset with three queued loads and a staged ALU write
    alu_valid = 1'b1; alu_wa = 5'd0; ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_wa = 5'(10 + i); ld_wd = 32'h300 + 32'(i);
      cyc();
    end
    ld_valid = 1'b0; alu_wa = 5'd20; alu_wd = 32'h2020;
    cyc();
    alu_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_rf_en", 32'(rf_en), 32'd0);
    chk("mrst_pend", pend_mask, 32'd0);
    chk("mrst_ready", 32'(ld_ready), 32'd1);
    rst_n = 1'b1;
    mq.delete();
    mo_en = 1'b0; mo_wa = '0; mo_wd = '0;
    repeat (5) cyc();
    chk("mrst_x10", dutf[10], 32'd0);
    chk("mrst_x20", dutf[20], 32'd0);

    // Random traffic with frequent register collisions
    repeat (400) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_wa    = 5'($urandom_range(0, 7));
      alu_wd    = $urandom;
      ld_valid  = ($urandom_range(0, 9) < 6);
      ld_wa     = 5'($urandom_range(0, 7));
      ld_wd     = $urandom;
      fwd_addr  = 5'($urandom_range(0, 7));
      cyc();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    repeat (DEPTH + 2) cyc();
    for (int r = 0; r < 32; r++) chk($sformatf("file_x%0d", r), dutf[r], mfile[r]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
